// File: rtl/systolic_sequencer.sv
// Instruction-driven controller for the 4x4 systolic matmul datapath.
// Each non-zero instruction runs fetch, clear, feed, drain and commit.
module systolic_sequencer #(
    parameter int INSTR_DEPTH = 8,
    parameter int IADDR_W     = 3,
    parameter int K_W         = 4,
    parameter int COL_W       = 8,
    parameter int ARRAY_DIM   = 4,
    parameter int OADDR_W     = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ap_start,
    output logic               ap_done,
    output logic               busy,
    output logic               instr_rd_en,
    output logic [IADDR_W-1:0] instr_addr,
    input  logic [K_W-1:0]     instr_data,
    output logic               arr_clr,
    output logic               in_rd_en,
    output logic [COL_W-1:0]   in_col,
    output logic               out_wr_en,
    output logic [OADDR_W-1:0] out_base,
    output logic [K_W-1:0]     cur_k
);

    localparam int DRAIN_LEN = 2 * ARRAY_DIM - 1;
    localparam int BASE_STEP = ARRAY_DIM * ARRAY_DIM;
    localparam int DL_W      = $clog2(DRAIN_LEN + 1);
    localparam int CNT_W     = (K_W > DL_W) ? K_W : DL_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IADDR_W-1:0] addr_q, addr_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [OADDR_W-1:0] base_q, base_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            col_q   <= '0;
            base_q  <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            col_q   <= col_d;
            base_q  <= base_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        col_d   = col_q;
        base_d  = base_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        unique case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    state_d = S_FETCH;
                    done_d  = 1'b0;
                    addr_d  = '0;
                    col_d   = '0;
                    base_d  = '0;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                k_d     = instr_data;
                state_d = (instr_data == '0) ? S_DONE : S_CLEAR;
            end
            S_CLEAR: begin
                cnt_d   = CNT_W'(k_q);
                state_d = S_FEED;
            end
            S_FEED: begin
                col_d = col_q + 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = CNT_W'(DRAIN_LEN);
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WRITE: begin
                base_d  = base_q + OADDR_W'(BASE_STEP);
                addr_d  = addr_q + 1'b1;
                // Running off the last slot ends the program like a halt.
                if (addr_q == IADDR_W'(INSTR_DEPTH - 1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign instr_rd_en = (state_q == S_FETCH);
    assign arr_clr     = (state_q == S_CLEAR);
    assign in_rd_en    = (state_q == S_FEED);
    assign out_wr_en   = (state_q == S_WRITE);
    assign ap_done     = done_q;
    assign instr_addr  = addr_q;
    assign in_col      = col_q;
    assign out_base    = base_q;
    assign cur_k       = k_q;

endmodule

// File: doc/systolic_sequencer.md
Name: systolic_sequencer

Overview:
Synchronous controller that sequences the 4x4 systolic matrix-multiply datapath from a small instruction memory, replacing the ad-hoc start/run logic in the top level. Each instruction word N (inner dimension) drives one pass: fetch, clear PE accumulators, stream N operand columns from the A/B input memories, drain the skewed array, then commit the 16 results to output memory. Instruction value 0, or exhausting the instruction memory, ends the program and raises ap_done.

Parameters:
INSTR_DEPTH, 8, number of instruction slots; program ends after the last slot.
IADDR_W, 3, instruction address width (log2 INSTR_DEPTH).
K_W, 4, instruction word width; N ranges 1..15.
COL_W, 8, input-memory column pointer width (256 columns).
ARRAY_DIM, 4, array side; drain length DRAIN_LEN = 2*ARRAY_DIM-1 = 7.
OADDR_W, 7, output-memory base address width; base steps by ARRAY_DIM*ARRAY_DIM = 16.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
ap_start  in  1  start pulse; sampled only in IDLE
ap_done  out  1  level; high from program end until next accepted ap_start or rst
busy  out  1  high in every state except IDLE
instr_rd_en  out  1  instruction memory read strobe
instr_addr  out  IADDR_W  instruction slot being fetched
instr_data  in  K_W  instruction word, valid the cycle after instr_rd_en
arr_clr  out  1  clears all PE accumulators and pipeline registers
in_rd_en  out  1  read strobe to A and B input memories
in_col  out  COL_W  column address presented with in_rd_en
out_wr_en  out  1  one-cycle commit of c0..c15 to output memory
out_base  out  OADDR_W  output-memory base for the current commit
cur_k  out  K_W  latched N of the pass in progress

Behaviour:
- Reset (any state, incl. mid-pass): state=IDLE; ap_done=0, busy=0, all strobes 0; instr_addr=0, in_col=0, out_base=0, cur_k=0. In-flight pass is abandoned, nothing written.
- All outputs are registered/Moore-decoded from state; no combinational path from inputs to outputs.
- States and transitions:
  IDLE: ap_start=1 -> FETCH, clear ap_done, instr_addr=0, in_col=0, out_base=0. ap_start=0 -> stay.
  FETCH (1 cycle): instr_rd_en=1 -> WAIT.
  WAIT (1 cycle): latch cur_k=instr_data. If instr_data==0 -> DONE, else -> CLEAR.
  CLEAR (1 cycle): arr_clr=1 -> FEED; load feed counter with cur_k.
  FEED (cur_k cycles): in_rd_en=1, in_col increments by 1 each cycle (mod 2^COL_W wrap); counter decrements; when counter reaches 1 -> DRAIN. in_col after FEED equals start+cur_k, so next pass continues contiguously.
  DRAIN (DRAIN_LEN cycles): all strobes 0; covers 1-cycle memory latency plus 2*(ARRAY_DIM-1) skew/propagation.
  WRITE (1 cycle): out_wr_en=1 with current out_base. Next cycle out_base += 16 (mod 128), instr_addr += 1. If instr_addr was INSTR_DEPTH-1 -> DONE, else -> FETCH.
  DONE (1 cycle): ap_done set to 1 -> IDLE.
- Pass latency for N>0: FETCH..WRITE = N+11 cycles; halt instruction: 2 cycles then DONE.
- ap_start while busy=1 is ignored (no restart, no queuing). ap_start in the same cycle ap_done is held in IDLE: accepted, ap_done drops next cycle.
- arr_clr, in_rd_en, out_wr_en are mutually exclusive; never two high in one cycle.
- Eight full passes wrap out_base back to 0 exactly at program end.

Test Plan:
- Program [4,0]: pulse ap_start -> arr_clr 1 cycle, in_rd_en 4 cycles with in_col 0,1,2,3, out_wr_en once at out_base 0 exactly 15 cycles after FETCH; ap_done high 2 cycles after second fetch's WAIT; matching reference A*B product in c0..c15.
- Program [4,2,3,0]: three commits at out_base 0,16,32; in_col sequences 0-3, 4-5, 6-8; ap_done level until next ap_start.
- Program [0]: ap_start -> FETCH, WAIT, DONE; no arr_clr, in_rd_en or out_wr_en ever asserted; ap_done=1 by cycle 4.
- Eight slots all N=15 with no halt: 8 commits at bases 0..112, ap_done after slot 7, out_base back to 0; in_col ends at 120.
- ap_start pulsed repeatedly during FEED -> ignored; pass counts and addresses unchanged.
- rst asserted on 3rd FEED cycle -> next cycle IDLE, all outputs 0, no out_wr_en; fresh ap_start reruns from instr_addr 0, in_col 0.
